// File: rtl/op_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : op_arb_pkg
// Purpose : Shared constants and helpers for the operator arbiters.
// Rev     : 1.0 - initial release
// ============================================================================
package op_arb_pkg;

    localparam int SIN_LATENCY = 36;
    localparam int OP_W        = 32;

    // Minimum of 1 so single-bit indices never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb
// Purpose : Round-robin one-hot arbiter with pointer, shared by math operators.
// Rev     : 1.0 - initial release
// ============================================================================
module rr_arb
    import op_arb_pkg::*;
#(
    parameter int N = 4
)(
    input  logic                c,
    input  logic                rst,
    input  logic                en,
    input  logic [N-1:0]        req,
    output logic [N-1:0]        gnt,
    output logic [clog2(N)-1:0] ptr
);

    localparam int PW = clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // Search order is ptr+1, ptr+2, ... modulo N; every index is a constant so
    // the loop unrolls into a fixed priority network per pointer value.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        if (en && !rst) begin
            for (int k = 1; k <= N; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && req[i] && (ptr_q == PW'((i - k + N) % N))) begin
                        found  = 1'b1;
                        gnt[i] = 1'b1;
                        ptr_d  = PW'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_d;

endmodule
`default_nettype wire

// File: rtl/op_sin_arb.sv
`default_nettype none
// ============================================================================
// Module  : op_sin_arb
// Purpose : Shares one pipelined sine core among N requesters, steering results back.
// Rev     : 1.0 - initial release
// ============================================================================
module op_sin_arb
    import op_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int LATENCY = SIN_LATENCY,
    parameter int TW      = 3
)(
    input  logic              c,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      req,
    input  logic [OP_W*N-1:0] d,
    output logic [N-1:0]      ack,
    output logic [OP_W-1:0]   q,
    output logic [N-1:0]      done,
    output logic              busy,
    output logic [OP_W-1:0]   sin_d,
    input  logic [OP_W-1:0]   sin_q
);

    localparam int PW = clog2(N);

    logic [N-1:0]    gnt;
    logic [PW-1:0]   gidx;
    logic            gnt_any;
    logic [OP_W-1:0] op_sel;
    logic [OP_W-1:0] sin_d_q;
    logic [OP_W-1:0] q_q;
    logic [N-1:0]    done_q;
    logic [N-1:0]    done_d;
    logic [LATENCY:0] vld_q;
    logic [TW-1:0]   tag_q [LATENCY+1];

    rr_arb #(.N(N)) u_arb (
        .c   (c),
        .rst (rst),
        .en  (en),
        .req (req),
        .gnt (gnt),
        .ptr (gidx)
    );

    assign gnt_any = |gnt;

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                op_sel = d[OP_W*i +: OP_W];
            end
        end
    end

    // Stage 0 lines up with the operand register; stage LATENCY with sin_q.
    always_comb begin
        done_d = '0;
        for (int i = 0; i < N; i++) begin
            done_d[i] = vld_q[LATENCY] && (tag_q[LATENCY] == TW'(i));
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            vld_q   <= '0;
            sin_d_q <= '0;
            q_q     <= '0;
            done_q  <= '0;
        end else begin
            vld_q  <= {vld_q[LATENCY-1:0], gnt_any};
            done_q <= done_d;
            if (gnt_any) begin
                sin_d_q <= op_sel;
            end
            if (vld_q[LATENCY]) begin
                q_q <= sin_q;
            end
        end
    end

    // Tags are qualified by vld_q, so they need no reset.
    always_ff @(posedge c) begin
        tag_q[0] <= TW'(gidx);
        for (int s = 1; s <= LATENCY; s++) begin
            tag_q[s] <= tag_q[s-1];
        end
    end

    assign ack   = gnt;
    assign sin_d = sin_d_q;
    assign q     = q_q;
    assign done  = done_q;
    assign busy  = |vld_q;

endmodule
`default_nettype wire

// File: doc/op_sin_arb.md
Name: op_sin_arb

Overview:
- Shares one fully pipelined single-precision sine core (fixed latency, no stall input) among N requesters.
- Round-robin arbiter issues at most one operand per cycle into the core.
- A tag/valid shift register tracks each in-flight operation so the result is steered back to its requester with a one-cycle done pulse.
- Sits between the motor-control math sequencers (commutation angle, field-oriented transforms) and the sine core instance.

Parameters:
- N, 4, number of requesters (2..8).
- LATENCY, 36, cycles from core data input valid to core result valid.
- TW, 3, tag width; must satisfy 2^TW >= N.

Ports:
- c  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  issue enable; 0 blocks new grants, in-flight ops still complete
- req  in  N  request per requester; level, held until ack
- d  in  32*N  operands; requester i uses bits [32*i+31:32*i]; stable while req[i]
- ack  out  N  one-hot combinational grant; req[i]&ack[i] at a rising edge = operand accepted
- q  out  32  registered shared result
- done  out  N  registered one-hot pulse; q valid for done[i] in the same cycle
- busy  out  1  1 while any operation is in flight
- sin_d  out  32  registered operand to core
- sin_q  in  32  core result

Behaviour:
- Reset values: sin_d=0, q=0, done=0, busy=0, rr pointer=N-1, all tag valids=0. ack is combinational; it is 0 while rst=1.
- Grant rule:
  - ack=0 when en=0 or no req.
  - Otherwise exactly one ack bit, for the first asserted req searching from ptr+1 modulo N.
  - On grant, ptr <= granted index.
  - Requests in the same cycle are served strictly round-robin; no requester waits more than N-1 grants.
- Issue: at the edge closing grant cycle t:
  - sin_d <= d slice of the grantee.
  - vld[0] <= 1, tag[0] <= index.
  - With no grant: vld[0] <= 0 and sin_d holds its value.
- Pipeline tracking: vld/tag shift one stage per cycle, depth LATENCY. The stage-LATENCY entry aligns with sin_q.
- Writeback:
  - At each edge, q <= sin_q and done <= onehot(tag) if the last stage is valid; else done <= 0.
  - q is not updated when no result retires.
- Latency: ack in cycle t -> done in cycle t+LATENCY+2 (default 38). Throughput is 1 op/cycle. Results leave in issue order.
- A requester may issue back-to-back; each grant yields exactly one done pulse.
- There is no backpressure: consumers must take q on the done cycle.
- busy = OR of all vld stages.
- en deassert mid-stream: no new grants; already-issued ops retire normally.
- rst mid-operation:
  - All valids clear, and no done fires for ops issued before reset.
  - Core contents are ignored. The first grant after reset completes normally.
- req dropped without ack: no effect; the pointer does not move.

Decomposition:
- Shared package op_arb_pkg holds:
  - constants SIN_LATENCY=36 and OP_W=32;
  - a tag-width function clog2(N).
- One sub-module, rr_arb: parameter N; inputs req, en, c, rst; outputs one-hot gnt and updated pointer. It is reusable for the cos/atan2 operators.
- Tag/valid delay line, operand mux and writeback registers stay in the top module.

Test Plan:
- Single op: req[2]=1, d[2]=0x3FC90FDB (pi/2), ack in cycle t -> done=4'b0100 at t+38, q = core output (~0x3F800000); no other done pulses.
- All four req held continuously from ptr=3:
  - ack sequence is 0,1,2,3,0,1...
  - done pulses arrive in the same order, one per cycle starting 38 cycles after the first ack.
- Back-to-back same requester: req[1] held 5 cycles with distinct operands -> 5 consecutive done[1] pulses; q matches a reference model, in order.
- en=0 with req pending: ack=0 and busy falls after the last in-flight done. Raising en -> grant within 1 cycle.
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle at +10 -> no done for those ops, busy=0 after the reset edge. A new op completes with correct latency.
- Fairness: req[0] held always while req[3] pulses on -> req[3] acked within N-1=3 cycles of asserting.
